// File: rtl/avst_channel_adapter_v2.sv
// avst_channel_adapter_v2
// Avalon-ST channel adapter. Widens or narrows the channel, latches it at SOP
// and applies it to the whole packet. Packets whose channel is above
// MAX_CHANNEL are discarded whole, and framing errors are flagged (sticky).
// Both the data path and the ready path are registered.
//
// Optional build macro: AVST_CHANNEL_ADAPTER_DROP_CNT_EN adds drop_count[15:0],
// a saturating count of packets dropped for an illegal channel.
//
// Buffering is a three-entry shift queue. Entry 0 is the output register and
// entry 1 is the skid register. Entry 2 is used only when an unexpected SOP
// in PKT produces two output beats: the synthetic EOP that closes the old
// packet, then the new SOP. in_ready is high only while the skid entry is
// empty, so at most one entry is occupied whenever a beat is accepted. That
// leaves room for two pushes even when the output register is stalled.
//
// state | meaning
// IDLE  | between packets, waiting for SOP
// PKT   | forwarding a legal packet
// DROP  | discarding a packet with an illegal channel

module avst_channel_adapter_v2 #(
  parameter int DATA_W        = 8,
  parameter int IN_CHANNEL_W  = 1,
  parameter int OUT_CHANNEL_W = 8,
  parameter int MAX_CHANNEL   = 255
) (
  input  logic                                            clk,
  input  logic                                            reset,
  output logic                                            in_ready,
  input  logic                                            in_valid,
  input  logic [DATA_W-1:0]                               in_data,
  input  logic [((IN_CHANNEL_W > 0) ? IN_CHANNEL_W : 1)-1:0] in_channel,
  input  logic                                            in_startofpacket,
  input  logic                                            in_endofpacket,
  input  logic                                            out_ready,
  output logic                                            out_valid,
  output logic [DATA_W-1:0]                               out_data,
  output logic [OUT_CHANNEL_W-1:0]                        out_channel,
  output logic                                            out_startofpacket,
  output logic                                            out_endofpacket,
`ifdef AVST_CHANNEL_ADAPTER_DROP_CNT_EN
  output logic [15:0]                                     drop_count,
`endif
  output logic                                            framing_error
);

  localparam int          IN_CW = (IN_CHANNEL_W > 0) ? IN_CHANNEL_W : 1;
  localparam logic [63:0] MAX_U = 64'(MAX_CHANNEL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]        data;
    logic [OUT_CHANNEL_W-1:0] ch;
    logic                     sop;
    logic                     eop;
  } beat_t;

  state_t                   state_q, state_d;
  logic [OUT_CHANNEL_W-1:0] chan_q, chan_d;
  logic                     ferr_q, ferr_d;
  logic                     in_ready_q, in_ready_d;
  beat_t                    fifo_q [3];
  beat_t                    fifo_d [3];
  logic [2:0]               vld_q, vld_d;

  logic [IN_CW-1:0]         ch_in;
  logic [OUT_CHANNEL_W-1:0] ch_map;
  logic                     ch_legal;
  logic                     accept;
  logic                     pop;
  logic                     push0, push1;
  beat_t                    b0, b1;

`ifdef AVST_CHANNEL_ADAPTER_DROP_CNT_EN
  logic [15:0]              dcnt_q, dcnt_d;
`endif
  logic                     drop_inc;

  assign accept = in_valid & in_ready_q;
  assign pop    = vld_q[0] & out_ready;

  // Effective channel, mapped channel and legality check. The legality check
  // uses the full input value, so truncation cannot hide an illegal channel.
  always_comb begin
    ch_in    = (IN_CHANNEL_W > 0) ? in_channel : '0;
    ch_map   = OUT_CHANNEL_W'(ch_in);
    ch_legal = (64'(ch_in) <= MAX_U);
  end

  // Packet FSM: decide which beats, if any, an accepted input beat produces.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    ferr_d   = ferr_q;
    push0    = 1'b0;
    push1    = 1'b0;
    b0       = '0;
    b1       = '0;
    drop_inc = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE, DROP: begin
          if (in_startofpacket) begin
            if (state_q == DROP) ferr_d = 1'b1;
            if (ch_legal) begin
              push0   = 1'b1;
              b0      = '{data: in_data, ch: ch_map, sop: 1'b1, eop: in_endofpacket};
              chan_d  = ch_map;
              state_d = in_endofpacket ? IDLE : PKT;
            end else begin
              drop_inc = 1'b1;
              state_d  = in_endofpacket ? IDLE : DROP;
            end
          end else if (state_q == IDLE) begin
            ferr_d = 1'b1;
          end else if (in_endofpacket) begin
            state_d = IDLE;
          end
        end
        PKT: begin
          if (in_startofpacket) begin
            // Close the open packet with a forced EOP on this beat, then
            // restart with this beat as the SOP of the new packet.
            ferr_d = 1'b1;
            push0  = 1'b1;
            b0     = '{data: in_data, ch: chan_q, sop: 1'b0, eop: 1'b1};
            if (ch_legal) begin
              push1   = 1'b1;
              b1      = '{data: in_data, ch: ch_map, sop: 1'b1, eop: in_endofpacket};
              chan_d  = ch_map;
              state_d = in_endofpacket ? IDLE : PKT;
            end else begin
              drop_inc = 1'b1;
              state_d  = in_endofpacket ? IDLE : DROP;
            end
          end else begin
            push0 = 1'b1;
            b0    = '{data: in_data, ch: chan_q, sop: 1'b0, eop: in_endofpacket};
            if (in_endofpacket) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/skid queue: drain the head first, then append the new beats in order.
  always_comb begin
    fifo_d = fifo_q;
    vld_d  = vld_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = fifo_q[2];
      vld_d     = {1'b0, vld_q[2:1]};
    end
    if (push0) begin
      if (!vld_d[0]) begin
        fifo_d[0] = b0;
        vld_d[0]  = 1'b1;
      end else if (!vld_d[1]) begin
        fifo_d[1] = b0;
        vld_d[1]  = 1'b1;
      end else begin
        fifo_d[2] = b0;
        vld_d[2]  = 1'b1;
      end
    end
    if (push1) begin
      if (!vld_d[0]) begin
        fifo_d[0] = b1;
        vld_d[0]  = 1'b1;
      end else if (!vld_d[1]) begin
        fifo_d[1] = b1;
        vld_d[1]  = 1'b1;
      end else begin
        fifo_d[2] = b1;
        vld_d[2]  = 1'b1;
      end
    end
    in_ready_d = ~vld_d[1];
  end

`ifdef AVST_CHANNEL_ADAPTER_DROP_CNT_EN
  // Saturating count of packets dropped for an illegal channel.
  always_comb begin
    dcnt_d = dcnt_q;
    if (drop_inc && (dcnt_q != 16'hFFFF)) dcnt_d = dcnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dcnt_q <= '0;
    else       dcnt_q <= dcnt_d;
  end

  assign drop_count = dcnt_q;
`endif

  // State, channel latch, error flag and queue registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      ferr_q     <= 1'b0;
      in_ready_q <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      ferr_q     <= ferr_d;
      in_ready_q <= in_ready_d;
      vld_q      <= vld_d;
      for (int i = 0; i < 3; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = vld_q[0];
  assign out_data          = fifo_q[0].data;
  assign out_channel       = fifo_q[0].ch;
  assign out_startofpacket = fifo_q[0].sop;
  assign out_endofpacket   = fifo_q[0].eop;
  assign framing_error     = ferr_q;

endmodule

// File: doc/avst_channel_adapter_v2.md
Name: avst_channel_adapter_v2

Overview:
- Parametrised Avalon-ST channel adapter. Successor to the fixed 8-bit, zero-channel packet-to-channel adapter used on the EMIF debug master path.
- Maps an IN_CHANNEL_W-bit input channel to an OUT_CHANNEL_W-bit output channel and inserts a registered skid stage, so the adapter breaks both the data path and the ready path.
- Whole packets whose channel exceeds MAX_CHANNEL are dropped, and framing errors are flagged.
- Sits between the packet/bytes converters and the channel-routed master interfaces.

Parameters:
- DATA_W, 8, payload width in bits
- IN_CHANNEL_W, 1, input channel width; 0 means no input channel, and the channel is treated as 0
- OUT_CHANNEL_W, 8, output channel width
- MAX_CHANNEL, 255, highest legal channel; packets above it are dropped

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_ready  out  1  sink ready; registered
- in_valid  in  1  sink valid
- in_data  in  DATA_W  sink payload
- in_channel  in  max(IN_CHANNEL_W,1)  sink channel
- in_startofpacket  in  1  sink SOP
- in_endofpacket  in  1  sink EOP
- out_ready  in  1  source ready
- out_valid  out  1  source valid
- out_data  out  DATA_W  source payload
- out_channel  out  OUT_CHANNEL_W  source channel
- out_startofpacket  out  1  source SOP
- out_endofpacket  out  1  source EOP
- framing_error  out  1  sticky framing error flag

Behaviour:
- Clocking and reset: single clock clk; reset is asynchronous, active-high.
- Reset values:
  - in_ready=0 while reset is asserted, 1 on the first cycle after release.
  - out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0.
  - framing_error=0; FSM=IDLE; skid empty.
- Handshake: a beat transfers on valid&ready; Avalon-ST readyLatency=0 on both sides.
- Output register: out_valid loads when it is empty or out_ready=1.
- Skid register: captures the accepted beat when out_valid=1 and out_ready=0.
- in_ready = ~skid_valid, registered. Full throughput, one beat per cycle with no bubbles.
- Latency: accepted beat appears on out_* on the next cycle.
- Channel mapping:
  - Zero-extend when OUT_CHANNEL_W >= IN_CHANNEL_W.
  - Otherwise truncate to the low bits; truncation never masks the MAX_CHANNEL check, which uses the full input value.
  - The channel is latched at SOP and applied to every beat of the packet; in_channel on non-SOP beats is ignored.
- FSM, evaluated on accepted input beats only:
  - IDLE:
    - SOP with channel <= MAX_CHANNEL: forward the beat; go to PKT, or stay in IDLE if EOP is also set.
    - SOP with channel > MAX_CHANNEL: discard; go to DROP, or stay in IDLE if EOP is also set.
    - Beat without SOP: discard; set framing_error; stay in IDLE.
  - PKT:
    - Forward beats; EOP returns to IDLE.
    - SOP without EOP: set framing_error, insert a synthetic EOP on the previous packet's end by forcing EOP on this beat's forward, then restart the packet with this beat's channel (the beat itself is forwarded as the new SOP one cycle later).
  - DROP:
    - Accept and discard all beats, keeping in_ready high.
    - EOP returns to IDLE.
    - SOP inside DROP sets framing_error and re-evaluates the channel as in IDLE.
- Dropped beats never occupy the output or skid registers.
- framing_error is cleared only by reset.
- Simultaneous events: the output draining and a new beat being accepted in the same cycle loads the output directly; the skid stays empty.
- Reset mid-packet: all state is discarded and the downstream sees no EOP; the next input must begin with SOP.

Optional Feature:
- Macro: AVST_CHANNEL_ADAPTER_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [15:0]: a saturating count of packets dropped for channel > MAX_CHANNEL, incremented on the dropped SOP beat.
  - Holds at 16'hFFFF once saturated; reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Setup: DATA_W=8, IN_CHANNEL_W=4, OUT_CHANNEL_W=8, MAX_CHANNEL=5.
- Legal packet: 4-beat packet ch=3, data 11,22,33,44, out_ready=1 -> same beats one cycle later, out_channel=8'h03 on all beats, SOP on 11, EOP on 44.
- Backpressure: out_ready=0 for 3 cycles mid-packet -> in_ready falls one cycle after the skid fills, no beat lost or duplicated, order preserved.
- Drop: 3-beat packet ch=9 followed by a packet ch=2 -> the ch=9 packet never appears and in_ready stays 1 throughout; the ch=2 packet is forwarded intact; drop_count=1 when enabled.
- Framing: a non-SOP beat in IDLE -> discarded and framing_error=1. Then SOP, data, SOP (no EOP between) -> first packet closed with EOP, second starts with SOP.
- Single-beat SOP+EOP packets back-to-back: ch=0 then ch=5 -> two 1-beat outputs on consecutive cycles, FSM stays in IDLE.
- Reset assertion mid-packet -> out_valid=0 immediately (asynchronous); after release in_ready=1 and the next SOP packet is forwarded normally.
